trace_arbiter: RTL
==================

# trace_arbiter

Two-source arbiter that shares a single `cpu_checker` instance between two CPU trace character streams. It forwards one character per clock, grants the checker to one source for a whole record (from `^` through `#`), and rotates grants round-robin at record boundaries. It sits directly in front of the checker's `char` input. It aborts records whose source stalls too long or that run past a length limit.

## Interface
- `TIMEOUT`, 8: max consecutive stall cycles tolerated mid-record before abort (1..255).
- `MAX_LEN`, 40: max characters forwarded per record, including `^` and `#`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `src0_char` in 8: source 0 character.
- `src0_valid` in 1: source 0 character present.
- `src0_ready` out 1: source 0 character accepted this cycle (combinational).
- `src1_char`, `src1_valid`, `src1_ready`: same as source 0, for source 1.
- `chk_char` out 8: registered character to the checker.
- `chk_src` out 1: source of the current `chk_char`.
- `busy` out 1: a record is in progress (state FWD).
- `abort` out 1: one-cycle pulse when a record is aborted.
- `rec_cnt0`, `rec_cnt1` out 16: completed records per source (stats option).
- `abort_cnt` out 16: aborted records (stats option).

## Operation
- **States:** IDLE, FWD. Registers:
  - `gnt`: 1 bit, current owner.
  - `last`: 1 bit, previous owner.
  - `len`: 6 bits.
  - `stall`: 8 bits.
- **IDLE:**
  - A source is a candidate when `valid && char=="^"`.
  - One candidate: it wins.
  - Two candidates: the source ≠ `last` wins.
  - Winner: ready=1, its `^` is forwarded, `gnt`←winner, `len`←1, `stall`←0, go to FWD.
  - Losing candidate: ready=0, so its `^` is held.
  - Valid non-`^` characters: ready=1 and discarded (resync); `chk_char`←8'h00.
- **FWD:**
  - Only `gnt` source has ready=1; the other has ready=0.
  - Granted valid char: forward it, `len`++, `stall`←0.
  - Granted char `#`: forward it, `last`←`gnt`, go to IDLE, increment `rec_cntN`.
  - Granted char `^` mid-record: forward it, `len`←1, stay in FWD (record restart, same owner).
  - Granted source not valid: `chk_char`←8'h00, `stall`++.
  - `stall` reaches `TIMEOUT` with no valid: abort.
  - Forwarding a non-`#` char that makes `len`==`MAX_LEN`: abort after that char.
- **Abort:**
  - `abort` pulses for 1 cycle and `abort_cnt` increments.
  - `last`←`gnt`, go to IDLE.
  - The next `chk_char` is 8'h00, which drives the checker back to its idle state.
- **Counters:** saturate at 16'hFFFF.
- **Reset values:**
  - `chk_char`=8'h00, `chk_src`=0, `busy`=0, `abort`=0, all counters 0.
  - State IDLE, `last`=1, so source 0 wins the first tie.

## Timing
- **Latency:** a character accepted in cycle n (ready&&valid at rising edge n) appears on `chk_char` after edge n, stable through cycle n+1.
- **Ready timing:** `srcN_ready` is combinational from state and `srcN_valid`/`srcN_char`; sources must hold char/valid until ready.
- **Throughput:** 1 char/clock. Back-to-back records from different sources take no extra cycle: the `#` edge returns to IDLE, and the next `^` is accepted the following cycle.
- **Timeout timing:** with `TIMEOUT`=8, after the last valid char, 8 bubble cycles emit 8'h00. The abort pulse coincides with the 8th bubble edge, and IDLE is reached that same edge.
- **Reset mid-record:** outputs drop to reset values asynchronously. Any partial record is lost without an abort pulse or count.
- **Simultaneous `#` and other source's `^`:** the `^` stays unaccepted that cycle and wins arbitration the next cycle.

## Configuration
- `TRACE_ARB_STATS_EN` defined: `rec_cnt0`, `rec_cnt1` and `abort_cnt` registers are implemented as described.
- Macro undefined: counter registers are omitted, and the three outputs are tied to 16'h0000. Arbitration and `abort` behaviour are identical.

## Test plan
- **Single record:** src0 sends "^10@00003000: $ 1 <= 0000000a#" with src1 idle.
  - `chk_char` reproduces the string 1 cycle delayed with `chk_src`=0.
  - `busy` falls after `#`.
  - `rec_cnt0`=1.
- **Simultaneous requests:** both sources present `^` in the same cycle after reset.
  - src0 is granted first and src1 is held (ready=0).
  - src1 is granted the cycle after src0's `#`.
  - A third tie goes to src0.
- **Idle garbage:** src1 sends "xyz" then a record while idle.
  - "xyz" is accepted and discarded with `chk_char`=8'h00.
  - The record is then forwarded intact.
- **Stall timeout:** src0 drops valid after "^10@" with `TIMEOUT`=8.
  - 8 cycles of 8'h00 follow, `abort` pulses once and `abort_cnt`=1.
  - A pending src1 `^` is granted the next cycle.
- **Length limit:** src0 sends 45 non-`#` chars after `^` with `MAX_LEN`=40.
  - Abort occurs after the 40th forwarded char.
  - Remaining chars are discarded in IDLE.
- **Reset mid-record:** assert `reset` between clock edges mid-record.
  - `busy`=0, `chk_char`=8'h00 and counters=0 immediately.
  - After release, a src1 `^` is granted.

Source files
------------

// File: rtl/trace_arbiter.sv
// trace_arbiter: shares one cpu_checker between two trace character streams.
// Grants a source for a whole record (^ .. #) and rotates round-robin at record
// boundaries. Records are aborted on a stall timeout or when they exceed MAX_LEN.
// Optional statistics counters are built when TRACE_ARB_STATS_EN is defined.
module trace_arbiter #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned MAX_LEN = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  src0_char,
  input  logic        src0_valid,
  output logic        src0_ready,
  input  logic [7:0]  src1_char,
  input  logic        src1_valid,
  output logic        src1_ready,
  output logic [7:0]  chk_char,
  output logic        chk_src,
  output logic        busy,
  output logic        abort,
  output logic [15:0] rec_cnt0,
  output logic [15:0] rec_cnt1,
  output logic [15:0] abort_cnt
);

  localparam logic [7:0] CharStart = 8'h5E;  // '^'
  localparam logic [7:0] CharEnd   = 8'h23;  // '#'
  localparam logic [6:0] MaxLen    = 7'(MAX_LEN);
  localparam logic [8:0] Timeout   = 9'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StFwd} state_e;

  state_e     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [5:0] len_q, len_d;
  logic [7:0] stall_q, stall_d;
  logic [7:0] chk_char_q, chk_char_d;
  logic       chk_src_q, chk_src_d;
  logic       abort_q, abort_d;

  logic       cand0, cand1, winner;
  logic       g_valid;
  logic [7:0] g_char;
  logic [6:0] len_inc;
  logic [8:0] stall_inc;
  logic       len_hit, stall_hit;

  assign cand0     = src0_valid && (src0_char == CharStart);
  assign cand1     = src1_valid && (src1_char == CharStart);
  // On a tie the source that did not own the previous record wins.
  assign winner    = (cand0 && cand1) ? ~last_q : cand1;
  assign g_valid   = gnt_q ? src1_valid : src0_valid;
  assign g_char    = gnt_q ? src1_char : src0_char;
  assign len_inc   = {1'b0, len_q} + 7'd1;
  assign stall_inc = {1'b0, stall_q} + 9'd1;
  // Only ordinary characters grow the record; ^ restarts it and # closes it.
  assign len_hit   = (g_char != CharStart) && (g_char != CharEnd) && (len_inc == MaxLen);
  assign stall_hit = (stall_inc == Timeout);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cand0 || cand1) state_d = StFwd;
      StFwd: begin
        if (g_valid) begin
          if ((g_char == CharEnd) || len_hit) state_d = StIdle;
        end else if (stall_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Non-^ characters are always swallowed to resync; a losing ^ is held.
        src0_ready = !cand0 || !winner;
        src1_ready = !cand1 || winner;
      end
      StFwd: begin
        src0_ready = ~gnt_q;
        src1_ready = gnt_q;
      end
      default: ;
    endcase
  end

  // Datapath next values: forwarded character, record length, stall and abort
  always_comb begin
    gnt_d      = gnt_q;
    last_d     = last_q;
    len_d      = len_q;
    stall_d    = stall_q;
    chk_char_d = 8'h00;
    chk_src_d  = chk_src_q;
    abort_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cand0 || cand1) begin
          gnt_d      = winner;
          chk_char_d = CharStart;
          chk_src_d  = winner;
          len_d      = 6'd1;
          stall_d    = 8'd0;
        end
      end
      StFwd: begin
        if (g_valid) begin
          chk_char_d = g_char;
          chk_src_d  = gnt_q;
          stall_d    = 8'd0;
          if (g_char == CharEnd) begin
            last_d = gnt_q;
          end else if (g_char == CharStart) begin
            len_d = 6'd1;
          end else begin
            len_d = len_inc[5:0];
            if (len_hit) begin
              abort_d = 1'b1;
              last_d  = gnt_q;
            end
          end
        end else begin
          stall_d = stall_inc[7:0];
          if (stall_hit) begin
            abort_d = 1'b1;
            last_d  = gnt_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      len_q      <= 6'd0;
      stall_q    <= 8'd0;
      chk_char_q <= 8'h00;
      chk_src_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      len_q      <= len_d;
      stall_q    <= stall_d;
      chk_char_q <= chk_char_d;
      chk_src_q  <= chk_src_d;
      abort_q    <= abort_d;
    end
  end

  assign chk_char = chk_char_q;
  assign chk_src  = chk_src_q;
  assign busy     = (state_q == StFwd);
  assign abort    = abort_q;

`ifdef TRACE_ARB_STATS_EN
  logic        rec_done0, rec_done1;
  logic [15:0] rec_cnt0_q, rec_cnt1_q, abort_cnt_q;

  assign rec_done0 = (state_q == StFwd) && g_valid && (g_char == CharEnd) && !gnt_q;
  assign rec_done1 = (state_q == StFwd) && g_valid && (g_char == CharEnd) && gnt_q;

  // Saturating statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_cnt0_q  <= 16'h0000;
      rec_cnt1_q  <= 16'h0000;
      abort_cnt_q <= 16'h0000;
    end else begin
      if (rec_done0 && (rec_cnt0_q != 16'hFFFF))  rec_cnt0_q  <= rec_cnt0_q + 16'd1;
      if (rec_done1 && (rec_cnt1_q != 16'hFFFF))  rec_cnt1_q  <= rec_cnt1_q + 16'd1;
      if (abort_d && (abort_cnt_q != 16'hFFFF))   abort_cnt_q <= abort_cnt_q + 16'd1;
    end
  end

  assign rec_cnt0  = rec_cnt0_q;
  assign rec_cnt1  = rec_cnt1_q;
  assign abort_cnt = abort_cnt_q;
`else
  assign rec_cnt0  = 16'h0000;
  assign rec_cnt1  = 16'h0000;
  assign abort_cnt = 16'h0000;
`endif

endmodule
